eight_x_eight: RTL and testbench
================================

EIGHT_X_EIGHT -- requirements
Module: eight_x_eight

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, signed operand width for A and B elements.
REQ-002 SHALL have parameter ACC_WIDTH, default 32, signed accumulator and result width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port enable, input, 1, advances the compute pipeline one step when high.
REQ-006 SHALL have port write, input, 1, loads b_in into weight row row_ptr when high.
REQ-007 SHALL have port row_ptr, input, 3, weight row index k (0..7) for write.
REQ-008 SHALL have port b_in, input, unpacked [8] x DATA_WIDTH signed, B[k][0..7].
REQ-009 SHALL have port a_in, input, unpacked [8] x DATA_WIDTH signed, one A row A[i][0..7], unskewed.
REQ-010 SHALL have port c_out, output, unpacked [8] x ACC_WIDTH signed, one C row C[i][0..7], deskewed.

Function
REQ-011 SHALL be a weight-stationary 8x8 systolic array: PE(k,j) holds B[k][j], A[i][k] flows along row k, partial sums flow down column j.
REQ-012 SHALL, on a rising edge with write=1, store b_in[j] into PE(row_ptr,j) for all j; other rows unchanged; enable is ignored for weight writes.
REQ-013 SHALL, on a rising edge with enable=1, sample a_in as one A row and advance every pipeline register by one stage.
REQ-014 SHALL, with enable=0, hold all pipeline registers and c_out unchanged (stall); weights still writable.
REQ-015 SHALL internally skew a_in (row k delayed k stages) and deskew outputs (column j delayed 7-j stages) so all eight c_out elements of one A row appear together.
REQ-016 SHALL present C[i][j] = sum over k of A[i][k]*B[k][j] on c_out after exactly 16 enabled edges following the edge that sampled A row i, holding until the next enabled edge.
REQ-017 SHALL accept one A row per enabled edge; consecutive rows produce consecutive c_out rows with no gaps.
REQ-018 SHALL compute each product as full signed 2*DATA_WIDTH, sign-extend to ACC_WIDTH, and add modulo 2^ACC_WIDTH (absent REQ-024).
REQ-019 SHALL, when write and enable coincide, let each PE use the weight it holds at the edge it multiplies; a write takes effect for products formed after that edge.
REQ-020 SHALL produce 0 on c_out for all-zero A rows (pipeline fill/drain).

Reset
REQ-021 SHALL, while rst=0, asynchronously clear all weights, skew/deskew registers, partial sums and c_out to 0.
REQ-022 SHALL, on rst assertion mid-computation, discard all in-flight rows; first valid result follows 16 enabled edges after the first post-reset A row.

Configuration
REQ-023 SHALL compile saturating accumulation only when macro EIGHT_X_EIGHT_SAT_EN is defined.
REQ-024 SHALL, with EIGHT_X_EIGHT_SAT_EN, clamp each partial sum to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]; without it, wrap per REQ-018.

Structure
REQ-025 SHALL take ARRAY_DIM=8, default DATA_WIDTH/ACC_WIDTH, LATENCY=16 and the operand/accumulator typedefs from shared package systolic_pkg.
REQ-026 SHALL build the array from 64 instances of sub-module systolic_pe (weight register, A forward register, multiply-accumulate register).

Verification
REQ-027 SHALL check 2x2 embed: write rows 0=[5,6,0..],1=[7,8,0..], rows 2-7 zero; A rows [1,2,0..],[3,4,0..] -> c_out[0..1]=19,22 then 43,50 on enabled edges 16,17; others 0.
REQ-028 SHALL check identity B with A row [1..8] -> c_out=[1..8] after 16 enabled edges.
REQ-029 SHALL check extremes: all A=-128, all B=-128 -> every c_out=131072; A=127, B=-128 -> every c_out=-130048.
REQ-030 SHALL check stall: enable low 5 cycles mid-stream -> results delayed exactly 5 cycles, values unchanged.
REQ-031 SHALL check rst asserted mid-stream -> c_out 0 immediately, weights 0, subsequent products 0 until reloaded.
REQ-032 SHALL check, with EIGHT_X_EIGHT_SAT_EN and ACC_WIDTH=16, all A=B=-128 -> every c_out=32767; without macro -> wrapped value 0.

Source files
------------

// File: rtl/systolic_pkg.sv
// systolic_pkg: shared sizes, types and helpers for the 8x8 weight-stationary array.
// Saturating accumulation is selected per build with EIGHT_X_EIGHT_SAT_EN.
package systolic_pkg;

  localparam int ARRAY_DIM  = 8;
  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 32;
  localparam int LATENCY    = 16;

  typedef logic signed [DATA_W_DEF-1:0] op_t;
  typedef logic signed [ACC_W_DEF-1:0]  acc_t;

  function automatic logic [ARRAY_DIM-1:0] row_sel(
    input logic [2:0] ptr
  );
    return ARRAY_DIM'(1) << ptr;
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// systolic_pe: one cell holding B[k][j]; forwards A right and partial sums down.
// EIGHT_X_EIGHT_SAT_EN clamps the partial sum instead of wrapping.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W_DEF,
  parameter int ACC_WIDTH  = ACC_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         i_wr,
  input  logic signed [DATA_WIDTH-1:0] i_b,
  input  logic signed [DATA_WIDTH-1:0] i_a,
  input  logic signed [ACC_WIDTH-1:0]  i_ps,
  output logic signed [DATA_WIDTH-1:0] o_a,
  output logic signed [ACC_WIDTH-1:0]  o_ps
);

  logic signed [DATA_WIDTH-1:0]   r_w;
  logic signed [DATA_WIDTH-1:0]   r_a;
  logic signed [ACC_WIDTH-1:0]    r_ps;
  logic signed [2*DATA_WIDTH-1:0] w_prod;
  logic signed [ACC_WIDTH-1:0]    w_prod_x;
  logic signed [ACC_WIDTH-1:0]    w_sum;

  assign w_prod   = (2*DATA_WIDTH)'(i_a)
                  * (2*DATA_WIDTH)'(r_w);
  assign w_prod_x = ACC_WIDTH'(w_prod);

`ifdef EIGHT_X_EIGHT_SAT_EN
  logic signed [ACC_WIDTH:0] w_wide;

  assign w_wide = (ACC_WIDTH+1)'(i_ps)
                + (ACC_WIDTH+1)'(w_prod_x);

  // Top two bits disagree only when the sum left the ACC range.
  always_comb begin
    w_sum = w_wide[ACC_WIDTH-1:0];
    if (w_wide[ACC_WIDTH] != w_wide[ACC_WIDTH-1]) begin
      w_sum = w_wide[ACC_WIDTH]
            ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
            : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
  end
`else
  assign w_sum = i_ps + w_prod_x;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_w  <= '0;
      r_a  <= '0;
      r_ps <= '0;
    end else begin
      if (i_wr) r_w <= i_b;
      if (enable) begin
        r_a  <= i_a;
        r_ps <= w_sum;
      end
    end
  end

  assign o_a  = r_a;
  assign o_ps = r_ps;

endmodule

// File: rtl/eight_x_eight.sv
// eight_x_eight: 8x8 weight-stationary systolic matrix multiplier, C row = A row x B.
// Define EIGHT_X_EIGHT_SAT_EN to build saturating partial sums.
module eight_x_eight
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W_DEF,
  parameter int ACC_WIDTH  = ACC_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         write,
  input  logic [2:0]                   row_ptr,
  input  logic signed [DATA_WIDTH-1:0] b_in  [ARRAY_DIM],
  input  logic signed [DATA_WIDTH-1:0] a_in  [ARRAY_DIM],
  output logic signed [ACC_WIDTH-1:0]  c_out [ARRAY_DIM]
);

  localparam int N   = ARRAY_DIM;
  localparam int DSK = LATENCY - ARRAY_DIM;

  logic [N-1:0]                 w_wr;
  logic signed [DATA_WIDTH-1:0] w_a_row [N];
  logic signed [DATA_WIDTH-1:0] w_a     [N][N];
  logic signed [ACC_WIDTH-1:0]  w_ps    [N][N];

  assign w_wr = write ? row_sel(row_ptr) : '0;

  // Row k sees its A element k+1 edges after sampling.
  for (genvar k = 0; k < N; k++) begin : g_skew
    logic signed [DATA_WIDTH-1:0] r_sk [k+1];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int m = 0; m <= k; m++) r_sk[m] <= '0;
      end else if (enable) begin
        r_sk[0] <= a_in[k];
        for (int m = 1; m <= k; m++) r_sk[m] <= r_sk[m-1];
      end
    end

    assign w_a_row[k] = r_sk[k];
  end

  for (genvar k = 0; k < N; k++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic signed [DATA_WIDTH-1:0] w_a_l;
      logic signed [ACC_WIDTH-1:0]  w_ps_u;

      if (j == 0) begin : g_a_edge
        assign w_a_l = w_a_row[k];
      end else begin : g_a_int
        assign w_a_l = w_a[k][j-1];
      end

      if (k == 0) begin : g_ps_edge
        assign w_ps_u = '0;
      end else begin : g_ps_int
        assign w_ps_u = w_ps[k-1][j];
      end

      systolic_pe #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
      ) u_pe (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .i_wr   (w_wr[k]),
        .i_b    (b_in[j]),
        .i_a    (w_a_l),
        .i_ps   (w_ps_u),
        .o_a    (w_a[k][j]),
        .o_ps   (w_ps[k][j])
      );
    end
  end

  // Column j finishes j edges late; the last stage doubles as c_out.
  for (genvar j = 0; j < N; j++) begin : g_dsk
    localparam int L = DSK - j;
    logic signed [ACC_WIDTH-1:0] r_d [L];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int m = 0; m < L; m++) r_d[m] <= '0;
      end else if (enable) begin
        r_d[0] <= w_ps[N-1][j];
        for (int m = 1; m < L; m++) r_d[m] <= r_d[m-1];
      end
    end

    assign c_out[j] = r_d[L-1];
  end

endmodule

// File: tb/tb_eight_x_eight.sv
// tb_eight_x_eight: scoreboard bench for eight_x_eight at ACC 32 and ACC 16.
// Expected rows come from a matrix-product model, checked 16 enabled edges later.
module tb_eight_x_eight;

  localparam int LAT = 16;

  typedef struct {
    int     due;
    string  tag;
    longint e32 [8];
    longint e16 [8];
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              enable = 1'b0;
  logic              write = 1'b0;
  logic [2:0]        row_ptr = '0;
  logic signed [7:0] a_in [8];
  logic signed [7:0] b_in [8];
  logic signed [31:0] c32 [8];
  logic signed [15:0] c16 [8];

  int   bm [8][8];
  exp_t q[$];
  int   n_en   = 0;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_row  = 0;

  always #5 clk = ~clk;

  eight_x_eight #(.DATA_WIDTH(8), .ACC_WIDTH(32)) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .write(write),
    .row_ptr(row_ptr), .b_in(b_in), .a_in(a_in), .c_out(c32)
  );

  eight_x_eight #(.DATA_WIDTH(8), .ACC_WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .enable(enable), .write(write),
    .row_ptr(row_ptr), .b_in(b_in), .a_in(a_in), .c_out(c16)
  );

  function automatic void chk(string name, longint got, longint want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endfunction

  // Bring a partial sum back into an aw-bit signed accumulator.
  function automatic longint fit(longint v, int aw);
    longint hi, lo;
    hi = (64'sd1 <<< (aw - 1)) - 1;
    lo = -(64'sd1 <<< (aw - 1));
`ifdef EIGHT_X_EIGHT_SAT_EN
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
`else
    begin
      longint m, r;
      m = 64'sd1 <<< aw;
      r = v & (m - 1);
      if (r > hi) r = r - m;
      return r;
    end
`endif
  endfunction

  function automatic void model(input int a[8], input int aw,
                                output longint c[8]);
    for (int j = 0; j < 8; j++) begin
      longint acc = 0;
      for (int k = 0; k < 8; k++)
        acc = fit(acc + longint'(a[k]) * longint'(bm[k][j]), aw);
      c[j] = acc;
    end
  endfunction

  function automatic void rnd_row(output int a[8]);
    for (int j = 0; j < 8; j++) a[j] = int'($urandom_range(0, 255)) - 128;
  endfunction

  function automatic void rnd_mat(output int m[8][8]);
    for (int r = 0; r < 8; r++)
      for (int j = 0; j < 8; j++) m[r][j] = int'($urandom_range(0, 255)) - 128;
  endfunction

  task automatic feed(input int a[8], input string tag);
    exp_t   e;
    longint t32 [8];
    longint t16 [8];
    @(negedge clk);
    enable = 1'b1;
    write  = 1'b0;
    for (int j = 0; j < 8; j++) a_in[j] = 8'(a[j]);
    model(a, 32, t32);
    model(a, 16, t16);
    e.due = n_en + 1 + LAT;
    e.tag = $sformatf("%s#%0d", tag, n_row);
    e.e32 = t32;
    e.e16 = t16;
    n_row++;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      enable = 1'b0;
      write  = 1'b0;
    end
  endtask

  task automatic wr(input int r, input int b[8]);
    @(negedge clk);
    enable  = 1'b0;
    write   = 1'b1;
    row_ptr = 3'(r);
    for (int j = 0; j < 8; j++) begin
      b_in[j]  = 8'(b[j]);
      bm[r][j] = b[j];
    end
  endtask

  task automatic load(input int m[8][8]);
    for (int r = 0; r < 8; r++) wr(r, m[r]);
  endtask

  // Zero rows leave nothing weight-dependent in flight before reloading.
  task automatic drain();
    int z [8] = '{default: 0};
    repeat (LAT) feed(z, "zero");
  endtask

  task automatic stall_chk(input int n);
    logic signed [31:0] s [8];
    @(negedge clk);
    enable = 1'b0;
    write  = 1'b0;
    s = c32;
    repeat (n) begin
      @(posedge clk);
      #1;
      for (int j = 0; j < 8; j++)
        chk($sformatf("stall hold c32[%0d]", j), longint'(c32[j]), longint'(s[j]));
    end
  endtask

  task automatic mid_reset();
    @(negedge clk);
    rst    = 1'b0;
    enable = 1'b0;
    write  = 1'b0;
    #1;
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("mid rst c32[%0d]", j), longint'(c32[j]), 0);
      chk($sformatf("mid rst c16[%0d]", j), longint'(c16[j]), 0);
    end
    q.delete();
    for (int r = 0; r < 8; r++)
      for (int j = 0; j < 8; j++) bm[r][j] = 0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin : mon
    exp_t e;
    forever begin
      @(posedge clk);
      if (enable && rst) n_en++;
      #1;
      while (q.size() > 0 && q[0].due <= n_en) begin
        e = q.pop_front();
        for (int j = 0; j < 8; j++) begin
          chk($sformatf("%s c32[%0d]", e.tag, j), longint'(c32[j]), e.e32[j]);
          chk($sformatf("%s c16[%0d]", e.tag, j), longint'(c16[j]), e.e16[j]);
        end
      end
    end
  end

  initial begin : stim
    int m  [8][8];
    int a  [8];
    for (int j = 0; j < 8; j++) begin
      a_in[j] = '0;
      b_in[j] = '0;
      for (int r = 0; r < 8; r++) bm[r][j] = 0;
    end

    @(negedge clk);
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("reset c32[%0d]", j), longint'(c32[j]), 0);
      chk($sformatf("reset c16[%0d]", j), longint'(c16[j]), 0);
    end
    rst = 1'b1;

    for (int r = 0; r < 8; r++)
      for (int j = 0; j < 8; j++) m[r][j] = 0;
    m[0][0] = 5; m[0][1] = 6;
    m[1][0] = 7; m[1][1] = 8;
    load(m);
    feed('{1, 2, 0, 0, 0, 0, 0, 0}, "emb2x2");
    feed('{3, 4, 0, 0, 0, 0, 0, 0}, "emb2x2");
    drain();

    for (int r = 0; r < 8; r++)
      for (int j = 0; j < 8; j++) m[r][j] = (r == j) ? 1 : 0;
    load(m);
    feed('{1, 2, 3, 4, 5, 6, 7, 8}, "ident");
    drain();

    for (int r = 0; r < 8; r++)
      for (int j = 0; j < 8; j++) m[r][j] = -128;
    load(m);
    feed('{default: -128}, "min_min");
    feed('{default: 127}, "max_min");
    drain();

    rnd_mat(m);
    load(m);
    repeat (6) begin rnd_row(a); feed(a, "pre_stall"); end
    stall_chk(5);
    repeat (6) begin rnd_row(a); feed(a, "post_stall"); end
    drain();

    rnd_mat(m);
    load(m);
    repeat (5) begin rnd_row(a); feed(a, "lost"); end
    mid_reset();
    repeat (4) begin rnd_row(a); feed(a, "no_wts"); end
    drain();
    rnd_mat(m);
    load(m);
    repeat (4) begin rnd_row(a); feed(a, "reload"); end
    drain();

    for (int t = 0; t < 3; t++) begin
      rnd_mat(m);
      load(m);
      repeat (20) begin
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        rnd_row(a);
        feed(a, "rand");
      end
      drain();
    end

    @(negedge clk);
    write = 1'b0;
    enable = 1'b1;
    for (int j = 0; j < 8; j++) a_in[j] = '0;
    repeat (LAT + 1) @(negedge clk);
    enable = 1'b0;
    idle(2);
    chk("queue empty", longint'(q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
